// File: rtl/axi_rd_arbiter.sv
// AXI4 read-channel arbiter: shares one downstream read port between the IFU (m0) and LSU (m1),
// with at most one read transaction outstanding.
module axi_rd_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [3:0]        m0_arid,
  input  logic [7:0]        m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic [1:0]        m0_arburst,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,
  output logic [3:0]        m0_rid,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [3:0]        m1_arid,
  input  logic [7:0]        m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic [1:0]        m1_arburst,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rlast,
  output logic [3:0]        m1_rid,
  output logic              s_arvalid,
  input  logic              s_arready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [3:0]        s_arid,
  output logic [7:0]        s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rlast,
  input  logic [3:0]        s_rid,
  output logic              busy,
  output logic              proto_err
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e     state_q, state_d;
  logic       grant_q, grant_d;
  logic       rr_ptr_q, rr_ptr_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic [7:0] arlen_q, arlen_d;
  logic [3:0] arid_q, arid_d;
  logic       proto_err_q, proto_err_d;

  logic sel_grant, gnt_arvalid, gnt_rready, ar_hs, r_hs;
  logic unused_rid;

  assign unused_rid  = ^s_rid;
  assign gnt_arvalid = grant_q ? m1_arvalid : m0_arvalid;
  assign gnt_rready  = grant_q ? m1_rready : m0_rready;
  assign ar_hs       = (state_q == StAddr) && gnt_arvalid && s_arready;
  assign r_hs        = (state_q == StData) && s_rvalid && gnt_rready;

  always_comb begin
    if (PRIO_MODE != 0) begin
      sel_grant = m1_arvalid;
    end else if (m0_arvalid && m1_arvalid) begin
      sel_grant = rr_ptr_q;
    end else begin
      sel_grant = m1_arvalid;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      grant_q     <= 1'b0;
      rr_ptr_q    <= 1'b0;
      beat_cnt_q  <= 8'd0;
      arlen_q     <= 8'd0;
      arid_q      <= 4'd0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      arlen_q     <= arlen_d;
      arid_q      <= arid_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    arlen_d     = arlen_q;
    arid_d      = arid_q;
    proto_err_d = proto_err_q;
    unique case (state_q)
      StIdle: begin
        if (m0_arvalid || m1_arvalid) begin
          grant_d = sel_grant;
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (ar_hs) begin
          arid_d     = grant_q ? m1_arid : m0_arid;
          arlen_d    = grant_q ? m1_arlen : m0_arlen;
          beat_cnt_d = 8'd0;
          state_d    = StData;
        end
      end
      StData: begin
        if (r_hs) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          // Flag rlast arriving early, or the final counted beat arriving without rlast.
          if (s_rlast != (beat_cnt_q == arlen_q)) proto_err_d = 1'b1;
          if (s_rlast) begin
            state_d  = StIdle;
            rr_ptr_d = ~grant_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    s_arvalid  = 1'b0;
    s_araddr   = '0;
    s_arid     = '0;
    s_arlen    = '0;
    s_arsize   = '0;
    s_arburst  = '0;
    s_rready   = 1'b0;
    m0_rvalid  = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = '0;
    m0_rlast   = 1'b0;
    m0_rid     = '0;
    m1_rvalid  = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = '0;
    m1_rlast   = 1'b0;
    m1_rid     = '0;
    unique case (state_q)
      StIdle: ;
      StAddr: begin
        s_arid    = {3'b000, grant_q};
        s_arvalid = gnt_arvalid;
        if (grant_q) begin
          s_araddr   = m1_araddr;
          s_arlen    = m1_arlen;
          s_arsize   = m1_arsize;
          s_arburst  = m1_arburst;
          m1_arready = s_arready;
        end else begin
          s_araddr   = m0_araddr;
          s_arlen    = m0_arlen;
          s_arsize   = m0_arsize;
          s_arburst  = m0_arburst;
          m0_arready = s_arready;
        end
      end
      StData: begin
        s_rready = gnt_rready;
        if (grant_q) begin
          m1_rvalid = s_rvalid;
          m1_rdata  = s_rdata;
          m1_rresp  = s_rresp;
          m1_rlast  = s_rlast;
          m1_rid    = arid_q;
        end else begin
          m0_rvalid = s_rvalid;
          m0_rdata  = s_rdata;
          m0_rresp  = s_rresp;
          m0_rlast  = s_rlast;
          m0_rid    = arid_q;
        end
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != StIdle);
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: a round-robin instance and a fixed-priority instance, driven with
// directed and random transactions and checked against a transaction-level model.
module tb_axi_rd_arbiter;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int          RBound = 400;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // Indexed [instance][master]; instance 0 is round-robin, instance 1 is fixed priority.
  logic              arvalid [2][2];
  logic              arready [2][2];
  logic [ADDR_W-1:0] araddr  [2][2];
  logic [3:0]        arid    [2][2];
  logic [7:0]        arlen   [2][2];
  logic [2:0]        arsize  [2][2];
  logic [1:0]        arburst [2][2];
  logic              rvalid  [2][2];
  logic              rready  [2][2];
  logic [DATA_W-1:0] rdata   [2][2];
  logic [1:0]        rresp   [2][2];
  logic              rlast   [2][2];
  logic [3:0]        rid     [2][2];
  logic              s_arvalid [2], s_arready [2], s_rvalid [2], s_rready [2], s_rlast [2];
  logic              busy [2], proto_err [2];
  logic [ADDR_W-1:0] s_araddr [2];
  logic [3:0]        s_arid [2], s_rid [2];
  logic [7:0]        s_arlen [2];
  logic [2:0]        s_arsize [2];
  logic [1:0]        s_arburst [2], s_rresp [2];
  logic [DATA_W-1:0] s_rdata [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PRIO_MODE(g)) u_dut (
      .clock(clock), .reset(reset),
      .m0_arvalid(arvalid[g][0]), .m0_arready(arready[g][0]), .m0_araddr(araddr[g][0]),
      .m0_arid(arid[g][0]), .m0_arlen(arlen[g][0]), .m0_arsize(arsize[g][0]),
      .m0_arburst(arburst[g][0]), .m0_rvalid(rvalid[g][0]), .m0_rready(rready[g][0]),
      .m0_rdata(rdata[g][0]), .m0_rresp(rresp[g][0]), .m0_rlast(rlast[g][0]), .m0_rid(rid[g][0]),
      .m1_arvalid(arvalid[g][1]), .m1_arready(arready[g][1]), .m1_araddr(araddr[g][1]),
      .m1_arid(arid[g][1]), .m1_arlen(arlen[g][1]), .m1_arsize(arsize[g][1]),
      .m1_arburst(arburst[g][1]), .m1_rvalid(rvalid[g][1]), .m1_rready(rready[g][1]),
      .m1_rdata(rdata[g][1]), .m1_rresp(rresp[g][1]), .m1_rlast(rlast[g][1]), .m1_rid(rid[g][1]),
      .s_arvalid(s_arvalid[g]), .s_arready(s_arready[g]), .s_araddr(s_araddr[g]),
      .s_arid(s_arid[g]), .s_arlen(s_arlen[g]), .s_arsize(s_arsize[g]),
      .s_arburst(s_arburst[g]), .s_rvalid(s_rvalid[g]), .s_rready(s_rready[g]),
      .s_rdata(s_rdata[g]), .s_rresp(s_rresp[g]), .s_rlast(s_rlast[g]), .s_rid(s_rid[g]),
      .busy(busy[g]), .proto_err(proto_err[g])
    );
  end

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int          last_m [2];  // master served last; on a round-robin tie the other one wins
  logic        perr_m [2];
  int          obs_gnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int k);
    if (!arvalid[k][0]) return 1;
    if (!arvalid[k][1]) return 0;
    if (k == 1) return 1;
    return 1 - last_m[k];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      last_m[k] = 1;
      perr_m[k] = 1'b0;
    end
  endtask

  task automatic clear_inputs(input int k);
    for (int m = 0; m < 2; m++) begin
      arvalid[k][m] = 1'b0;
      araddr[k][m]  = '0;
      arid[k][m]    = '0;
      arlen[k][m]   = '0;
      arsize[k][m]  = '0;
      arburst[k][m] = '0;
      rready[k][m]  = 1'b0;
    end
    s_arready[k] = 1'b0;
    s_rvalid[k]  = 1'b0;
    s_rdata[k]   = '0;
    s_rresp[k]   = '0;
    s_rlast[k]   = 1'b0;
    s_rid[k]     = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs(0);
    clear_inputs(1);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic req(input int k, input int m, input logic [ADDR_W-1:0] a, input logic [3:0] id,
                     input logic [7:0] len);
    arvalid[k][m] = 1'b1;
    araddr[k][m]  = a;
    arid[k][m]    = id;
    arlen[k][m]   = len;
    arsize[k][m]  = 3'($urandom_range(0, 2));
    arburst[k][m] = 2'b01;
  endtask

  task automatic check_idle(input int k);
    check("idle_busy", 64'(busy[k]), 64'd0);
    check("idle_arready", 64'({arready[k][0], arready[k][1]}), 64'd0);
    check("idle_rvalid", 64'({rvalid[k][0], rvalid[k][1]}), 64'd0);
    check("idle_s_arvalid", 64'(s_arvalid[k]), 64'd0);
    check("idle_s_rready", 64'(s_rready[k]), 64'd0);
    check("proto_err", 64'(proto_err[k]), 64'(perr_m[k]));
  endtask

  // err: 0 clean, 1 rlast on beat 2, 2 one extra beat before rlast. abort_at: beat index to reset on.
  task automatic run_txn(input int k, input int stall, input bit toggle, input bit seq,
                         input int err, input int abort_at);
    int g, o, nb, beat, cyc;
    bit rv, rr, lst, aborted;
    logic [DATA_W-1:0] d;
    logic [1:0] resp;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] obs_q[$];
    g = pick(k);
    o = 1 - g;
    check_idle(k);
    @(negedge clock);
    obs_gnt = int'(s_arid[k]);
    check("ar_busy", 64'(busy[k]), 64'd1);
    check("ar_valid", 64'(s_arvalid[k]), 64'd1);
    check("ar_addr", 64'(s_araddr[k]), 64'(araddr[k][g]));
    check("ar_id", 64'(s_arid[k]), 64'(g));
    check("ar_len", 64'(s_arlen[k]), 64'(arlen[k][g]));
    check("ar_size", 64'(s_arsize[k]), 64'(arsize[k][g]));
    check("ar_burst", 64'(s_arburst[k]), 64'(arburst[k][g]));
    for (int i = 0; i < stall; i++) begin
      check("ar_stall_ready", 64'({arready[k][0], arready[k][1]}), 64'd0);
      @(negedge clock);
    end
    s_arready[k] = 1'b1;
    #1;
    check("ar_ready_gnt", 64'(arready[k][g]), 64'd1);
    check("ar_ready_other", 64'(arready[k][o]), 64'd0);
    @(negedge clock);
    s_arready[k]  = 1'b0;
    arvalid[k][g] = 1'b0;
    nb = (err == 1) ? 2 : (err == 2) ? int'(arlen[k][g]) + 2 : int'(arlen[k][g]) + 1;
    beat = 0;
    cyc = 0;
    aborted = 1'b0;
    while (beat < nb && cyc < RBound && !aborted) begin
      if (beat == abort_at) begin
        s_rvalid[k] = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        clear_inputs(0);
        clear_inputs(1);
        model_reset();
        #1;
        check_idle(0);
        check_idle(1);
        aborted = 1'b1;
      end else begin
        rv   = ($urandom_range(0, 3) != 0);
        rr   = toggle ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
        d    = seq ? DATA_W'(32'h11 * (beat + 1)) : DATA_W'($urandom);
        resp = 2'($urandom);
        lst  = (beat == nb - 1);
        s_rvalid[k]  = rv;
        s_rdata[k]   = d;
        s_rresp[k]   = resp;
        s_rlast[k]   = lst;
        s_rid[k]     = 4'($urandom);
        rready[k][g] = rr;
        rready[k][o] = 1'($urandom);
        #1;
        check("r_valid", 64'(rvalid[k][g]), 64'(rv));
        check("r_valid_other", 64'(rvalid[k][o]), 64'd0);
        check("s_rready", 64'(s_rready[k]), 64'(rr));
        if (rv) begin
          check("r_data", 64'(rdata[k][g]), 64'(d));
          check("r_resp", 64'(rresp[k][g]), 64'(resp));
          check("r_last", 64'(rlast[k][g]), 64'(lst));
          check("r_id", 64'(rid[k][g]), 64'(arid[k][g]));
        end
        if (rvalid[k][g] && rready[k][g]) obs_q.push_back(rdata[k][g]);
        if (rv && rr) exp_q.push_back(d);
        @(negedge clock);
        if (rv && rr) beat++;
        cyc++;
      end
    end
    if (!aborted) begin
      s_rvalid[k]  = 1'b0;
      s_rlast[k]   = 1'b0;
      rready[k][0] = 1'b0;
      rready[k][1] = 1'b0;
      check("r_cycle_bound", 64'(cyc < RBound), 64'd1);
      check("r_beat_count", 64'(obs_q.size()), 64'(nb));
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        check("r_order", 64'(obs_q[i]), 64'(exp_q[i]));
      end
      check("end_busy", 64'(busy[k]), 64'd0);
      last_m[k] = g;
      if (err != 0) perr_m[k] = 1'b1;
      check("end_proto_err", 64'(proto_err[k]), 64'(perr_m[k]));
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs(0);
    clear_inputs(1);
    do_reset();
    for (int k = 0; k < 2; k++) begin
      check_idle(k);
      check("rst_araddr", 64'(s_araddr[k]), 64'd0);
      check("rst_rdata", 64'(rdata[k][0]), 64'd0);
    end

    // Single m0 INCR burst with sequential data.
    req(0, 0, 32'h8000_0000, 4'h3, 8'd3);
    run_txn(0, 0, 1'b0, 1'b1, 0, -1);
    check("single_gnt", 64'(obs_gnt), 64'd0);

    // Round-robin alternation with both requesting.
    do_reset();
    req(0, 0, 32'h0000_1000, 4'h2, 8'd0);
    req(0, 1, 32'h0000_2000, 4'h5, 8'd0);
    run_txn(0, 0, 1'b0, 1'b0, 0, -1);
    check("rr_first", 64'(obs_gnt), 64'd0);
    req(0, 0, 32'h0000_1004, 4'h2, 8'd0);
    run_txn(0, 0, 1'b0, 1'b0, 0, -1);
    check("rr_second", 64'(obs_gnt), 64'd1);
    req(0, 1, 32'h0000_2004, 4'h5, 8'd0);
    run_txn(0, 0, 1'b0, 1'b0, 0, -1);
    check("rr_third", 64'(obs_gnt), 64'd0);

    // Fixed priority: m1 wins until it stops requesting.
    do_reset();
    req(1, 0, 32'h0000_3000, 4'h1, 8'd1);
    req(1, 1, 32'h0000_4000, 4'h6, 8'd0);
    run_txn(1, 0, 1'b0, 1'b0, 0, -1);
    check("prio_first", 64'(obs_gnt), 64'd1);
    req(1, 1, 32'h0000_4010, 4'h6, 8'd2);
    run_txn(1, 1, 1'b0, 1'b0, 0, -1);
    check("prio_second", 64'(obs_gnt), 64'd1);
    run_txn(1, 0, 1'b0, 1'b0, 0, -1);
    check("prio_m0_last", 64'(obs_gnt), 64'd0);

    // Downstream AR stall with toggling rready.
    do_reset();
    req(0, 0, 32'h0000_5000, 4'h1, 8'd3);
    run_txn(0, 5, 1'b1, 1'b1, 0, -1);

    // Reset on beat 2, then arbitration restarts favouring m0.
    req(0, 0, 32'h0000_6000, 4'h1, 8'd3);
    run_txn(0, 0, 1'b0, 1'b0, 0, 1);
    req(0, 0, 32'h0000_6100, 4'h4, 8'd1);
    req(0, 1, 32'h0000_7000, 4'h7, 8'd2);
    run_txn(0, 0, 1'b0, 1'b0, 0, -1);
    check("post_rst_gnt", 64'(obs_gnt), 64'd0);
    run_txn(0, 0, 1'b0, 1'b0, 0, -1);
    check("post_rst_m1", 64'(obs_gnt), 64'd1);

    // Early rlast sets a sticky error; later traffic still completes.
    do_reset();
    req(0, 0, 32'h0000_8000, 4'h2, 8'd3);
    run_txn(0, 0, 1'b0, 1'b0, 1, -1);
    req(0, 1, 32'h0000_9000, 4'h9, 8'd1);
    run_txn(0, 0, 1'b0, 1'b0, 0, -1);
    check("perr_sticky", 64'(proto_err[0]), 64'd1);

    // Random traffic on each instance in turn.
    for (int k = 0; k < 2; k++) begin
      do_reset();
      for (int it = 0; it < 25; it++) begin
        int g, err;
        for (int m = 0; m < 2; m++) begin
          if (!arvalid[k][m] && $urandom_range(0, 1) == 1) begin
            req(k, m, ADDR_W'($urandom), 4'($urandom), 8'($urandom_range(0, 5)));
          end
        end
        if (!arvalid[k][0] && !arvalid[k][1]) begin
          req(k, int'($urandom_range(0, 1)), ADDR_W'($urandom), 4'($urandom),
              8'($urandom_range(0, 5)));
        end
        g = pick(k);
        err = 0;
        if ($urandom_range(0, 9) == 0) err = (arlen[k][g] >= 8'd2) ? 1 : 2;
        run_txn(k, int'($urandom_range(0, 2)), 1'b0, 1'b0, err, -1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- 2-to-1 AXI4 read-channel arbiter that shares the single CPU read master port between the IFU (m0) and the LSU (m1).
- Sits between the core's fetch and load units and the downstream AXI4 memory slave. That slave accepts one AR at a time and returns INCR bursts.
- At most one read transaction is outstanding; the grant is held from AR accept until the last R beat is accepted.
- Write channels bypass this block.

Parameters:
- ADDR_W, 32, address width of all AR channels.
- DATA_W, 32, R data width.
- PRIO_MODE, 0, arbitration policy: 0 = round-robin; 1 = fixed priority, m1 (LSU) wins.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous active-high reset
- m0_arvalid/m1_arvalid  in  1  requester AR valid
- m0_arready/m1_arready  out  1  requester AR ready
- m0_araddr/m1_araddr  in  ADDR_W  requester address
- m0_arid/m1_arid  in  4  requester ID
- m0_arlen/m1_arlen  in  8  burst length minus 1
- m0_arsize/m1_arsize  in  3  beat size
- m0_arburst/m1_arburst  in  2  burst type
- m0_rvalid/m1_rvalid  out  1  requester R valid
- m0_rready/m1_rready  in  1  requester R ready
- m0_rdata/m1_rdata  out  DATA_W  requester R data
- m0_rresp/m1_rresp  out  2  requester R response
- m0_rlast/m1_rlast  out  1  requester R last
- m0_rid/m1_rid  out  4  requester R ID
- s_arvalid  out  1  downstream AR valid
- s_arready  in  1  downstream AR ready
- s_araddr  out  ADDR_W  downstream address
- s_arid  out  4  downstream ID
- s_arlen  out  8  downstream burst length
- s_arsize  out  3  downstream beat size
- s_arburst  out  2  downstream burst type
- s_rvalid  in  1  downstream R valid
- s_rready  out  1  downstream R ready
- s_rdata  in  DATA_W  downstream R data
- s_rresp  in  2  downstream R response
- s_rlast  in  1  downstream R last
- s_rid  in  4  downstream R ID
- busy  out  1  transaction in progress (state != IDLE)
- proto_err  out  1  sticky burst-length mismatch flag

Behaviour:
- Interface: reset is synchronous, active-high; clock is clock.
- Reset state: state=IDLE, grant=0, rr_ptr=0 (m0 favoured), beat_cnt=0, proto_err=0.
- Reset output values: all valid/ready outputs = 0, busy=0. Data/addr outputs are don't-care but driven as 0.
- FSM IDLE:
  - If any mX_arvalid, register the grant and go to ADDR.
  - Round-robin: if both valid, grant rr_ptr; otherwise grant the single requester.
  - PRIO_MODE=1: m1 wins whenever m1_arvalid.
  - All arready = 0 in IDLE.
- FSM ADDR:
  - s_ar* fields = granted master's fields; s_arid = {3'b0, grant}.
  - s_arvalid = granted mX_arvalid; granted mX_arready = s_arready; the other arready = 0.
  - On the s_arvalid & s_arready handshake: latch the master's arid and arlen, set beat_cnt=0, go to DATA.
- FSM DATA:
  - Granted mX_rvalid = s_rvalid; s_rready = granted mX_rready.
  - mX_rdata/rresp/rlast pass through combinationally; mX_rid = latched arid.
  - The non-granted master sees rvalid=0.
  - On each beat handshake: beat_cnt += 1.
  - On handshake with s_rlast=1: go to IDLE and set rr_ptr = ~grant.
- Latency: AR reaches the slave 1 cycle after arvalid is seen in IDLE. R path adds 0 cycles. Minimum 1 idle cycle between transactions.
- A master whose arvalid is not granted waits indefinitely with arvalid high and must hold its fields stable (AXI rule). Deasserting arvalid in ADDR is a protocol violation and behaviour is not defined.
- proto_err:
  - Set if s_rlast arrives when beat_cnt != latched arlen.
  - Set if a beat is accepted with beat_cnt == arlen but s_rlast=0. In that case the FSM stays in DATA until rlast.
  - Cleared only by reset.
- Simultaneous events:
  - A new request arriving in the same cycle as a last beat is arbitrated in the following IDLE cycle, using the updated rr_ptr.
  - In round-robin mode, continuous requests alternate m0, m1, m0, ...
- Reset mid-burst: immediate return to IDLE. The downstream slave shares the same reset.
- s_rid is ignored; s_rresp passes through unchanged.

Test Plan:
- m0 INCR burst, arlen=3, araddr=0x8000_0000 → s_arvalid one cycle after m0_arvalid, s_arid=0; 4 beats reach m0 with rlast on beat 4; m1_rvalid stays 0; busy drops one cycle after the last beat.
- m0 and m1 assert arvalid in the same cycle, PRIO_MODE=0, arlen=0 → m0 granted first, then m1, then m0 again while both keep requesting; m1_rid equals m1_arid=0x5.
- PRIO_MODE=1 with both requesting continuously → m1 is always granted; m0 is not granted until m1_arvalid=0.
- Downstream stalls: s_arready held 0 for 5 cycles and m0_rready toggled every cycle → m0_arready held 0 during the stall; no beat lost or duplicated; data order is 0x11, 0x22, 0x33, 0x44.
- reset asserted on beat 2 of a 4-beat burst → next cycle busy=0, all valid/ready outputs = 0, rr_ptr=0; a new m1 request completes normally.
- Slave returns rlast on beat 2 of an arlen=3 burst → proto_err=1 and stays set; FSM returns to IDLE; a subsequent transaction still completes.
